food_spawner: RTL and testbench
===============================

// Module: food_spawner
// PURPOSE
//  Places food on the snake grid and detects when the snake head eats it.
//  Produces the one-cycle get_food pulse that the score counter consumes.
//  Draws candidate cells from a 16-bit LFSR and checks each one against the body-occupancy
//  map over a request/response port. Falls back to a linear scan when random picks keep
//  landing on the body.
// PARAMETERS
//  GRID_W     32       grid width in cells; legal x = 0..GRID_W-1
//  GRID_H     24       grid height in cells; legal y = 0..GRID_H-1
//  XW         5        x coordinate width
//  YW         5        y coordinate width
//  LFSR_SEED  16'hACE1 LFSR reset value; must be non-zero
//  MAX_TRIES  64       rejected random candidates allowed before scan mode starts
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  rst_n       in   1   synchronous reset, active-low
//  game_state  in   2   00=playing, 01=paused, 10=restart, 11=game over
//  move_tick   in   1   one-cycle strobe: snake advanced; head_x/head_y valid this cycle
//  head_x      in   XW  snake head x
//  head_y      in   YW  snake head y
//  occ_req     out  1   one-cycle occupancy query strobe
//  occ_x       out  XW  queried x, held stable from occ_req until response
//  occ_y       out  YW  queried y, held stable from occ_req until response
//  occ_hit     in   1   valid exactly 1 cycle after occ_req; 1 = cell holds body
//  food_x      out  XW  current food x, meaningful only while food_valid=1
//  food_y      out  YW  current food y, meaningful only while food_valid=1
//  food_valid  out  1   food placed and visible
//  get_food    out  1   one-cycle pulse: food eaten
//  spawn_fail  out  1   sticky: no free cell exists
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - all outputs 0, state IDLE, tries=0, lfsr=LFSR_SEED.
//  LFSR
//   - 16-bit Galois, taps x^16+x^14+x^13+x^11; steps every cycle in every state.
//   - if it ever holds 0, reload LFSR_SEED.
//  States
//   - IDLE: food_valid=0. If game_state==00 -> PICK.
//   - PICK: candidate x = lfsr[XW-1:0], y = lfsr[XW+YW-1:XW].
//     - out of range (x>=GRID_W or y>=GRID_H): tries++, stay in PICK.
//     - in range: latch candidate -> QUERY.
//   - QUERY: occ_req=1 for exactly one cycle with occ_x/occ_y = candidate -> WAIT.
//   - WAIT: sample occ_hit.
//     - occ_hit=0: food_x/y <= candidate, food_valid <= 1 -> ACTIVE.
//     - occ_hit=1: tries++ -> PICK (random mode) or next scan cell -> QUERY (scan mode).
//   - ACTIVE: if game_state==00 && move_tick && head==food:
//     - next cycle get_food=1 for 1 cycle, food_valid=0, tries=0 -> PICK.
//  Spawn latency
//   - minimum: food_valid rises 3 cycles after entering PICK (PICK, QUERY, WAIT).
//  Scan mode
//   - entered when tries reaches MAX_TRIES (checked in PICK/WAIT); start cell = last candidate.
//   - next cell = x+1; wrap x to 0 with y+1; wrap y to 0 after GRID_H-1.
//   - after GRID_W*GRID_H consecutive hits: spawn_fail=1, state HALT, food_valid=0.
//   - HALT is left only via restart or reset.
//  game_state
//   - 10 (restart): next cycle -> IDLE, all outputs except food_x/y cleared
//     (occ_req, food_valid, get_food, spawn_fail, tries, scan flag). Aborts any query;
//     an occ_hit arriving afterwards is ignored.
//   - 01 / 11: no eating and no get_food; an in-progress spawn completes; IDLE does not exit.
//  Pulse rules
//   - at most one get_food pulse per placed food; move_tick while not ACTIVE is ignored.
//   - rst_n=0 mid-operation: immediate reset values; no partial pulse.
// TESTING
//  T1 rst_n=0 for 2 cycles, then game_state=00, occ_hit=0
//     -> one occ_req; food_valid=1 with food_x<32, food_y<24; get_food stays 0.
//  T2 ACTIVE at food (x,y); move_tick with head=(x,y)
//     -> get_food=1 for exactly 1 cycle, food_valid=0, new food within 3+ cycles;
//     head != food -> no pulse.
//  T3 occ_hit=1 for first 3 queries, then 0
//     -> exactly 4 occ_req pulses; food equals 4th queried cell.
//  T4 occ_hit=1 except cell (7,5)
//     -> scan mode entered after 64 tries; food_valid with food=(7,5).
//  T5 occ_hit always 1
//     -> spawn_fail=1 after 768 scanned cells; food_valid=0;
//     game_state=10 clears spawn_fail next cycle.
//  T6 game_state=10 while in WAIT -> next cycle IDLE, occ_req=0, no get_food;
//     game_state=01 with head on food + move_tick -> no get_food.

Source files
------------

// File: rtl/food_spawner.sv
// food_spawner: places food on free grid cells via LFSR picks and detects the head eating it
module food_spawner #(
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 24,
    parameter int          XW        = 5,
    parameter int          YW        = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_game_state,
    input  logic          i_move_tick,
    input  logic [XW-1:0] i_head_x,
    input  logic [YW-1:0] i_head_y,
    output logic          o_occ_req,
    output logic [XW-1:0] o_occ_x,
    output logic [YW-1:0] o_occ_y,
    input  logic          i_occ_hit,
    output logic [XW-1:0] o_food_x,
    output logic [YW-1:0] o_food_y,
    output logic          o_food_valid,
    output logic          o_get_food,
    output logic          o_spawn_fail
);
    localparam int              TW     = $clog2(MAX_TRIES + 1);
    localparam int              CW     = $clog2(GRID_W * GRID_H + 1);
    localparam logic [XW:0]     X_LIM  = (XW+1)'(GRID_W);
    localparam logic [YW:0]     Y_LIM  = (YW+1)'(GRID_H);
    localparam logic [XW-1:0]   X_MAX  = XW'(GRID_W - 1);
    localparam logic [YW-1:0]   Y_MAX  = YW'(GRID_H - 1);
    localparam logic [TW-1:0]   T_MAX  = TW'(MAX_TRIES);
    localparam logic [CW-1:0]   C_LAST = CW'(GRID_W * GRID_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_QUERY, S_WAIT, S_ACTIVE, S_HALT} state_t;

    state_t        r_state, w_state;
    logic [15:0]   r_lfsr, w_lfsr;
    logic [TW-1:0] r_tries, w_tries;
    logic          r_scan, w_scan;
    logic [CW-1:0] r_scan_cnt, w_scan_cnt;
    logic [XW-1:0] r_cx, w_cx, r_food_x, w_food_x;
    logic [YW-1:0] r_cy, w_cy, r_food_y, w_food_y;
    logic          r_food_valid, w_food_valid;
    logic          r_get_food, w_get_food;
    logic          r_spawn_fail, w_spawn_fail;
    logic [XW-1:0] w_rx, w_sx;
    logic [YW-1:0] w_ry, w_sy;
    logic          w_in_range, w_restart, w_eat;

    assign w_rx       = r_lfsr[XW-1:0];
    assign w_ry       = r_lfsr[XW+YW-1:XW];
    assign w_in_range = ({1'b0, w_rx} < X_LIM) && ({1'b0, w_ry} < Y_LIM);
    assign w_sx       = (r_cx == X_MAX) ? '0 : r_cx + 1'b1;
    assign w_sy       = (r_cx != X_MAX) ? r_cy : (r_cy == Y_MAX) ? '0 : r_cy + 1'b1;
    assign w_restart  = i_game_state == 2'b10;
    assign w_eat      = i_game_state == 2'b00 && i_move_tick &&
                        i_head_x == r_food_x && i_head_y == r_food_y;
    assign w_lfsr     = (r_lfsr == '0) ? LFSR_SEED :
                        ({1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000));

    assign o_occ_req    = r_state == S_QUERY;
    assign o_occ_x      = r_cx;
    assign o_occ_y      = r_cy;
    assign o_food_x     = r_food_x;
    assign o_food_y     = r_food_y;
    assign o_food_valid = r_food_valid;
    assign o_get_food   = r_get_food;
    assign o_spawn_fail = r_spawn_fail;

    // Next-state and datapath updates; restart overrides every state and drops any pending query
    always_comb begin
        w_state      = r_state;
        w_tries      = r_tries;
        w_scan       = r_scan;
        w_scan_cnt   = r_scan_cnt;
        w_cx         = r_cx;
        w_cy         = r_cy;
        w_food_x     = r_food_x;
        w_food_y     = r_food_y;
        w_food_valid = r_food_valid;
        w_get_food   = 1'b0;
        w_spawn_fail = r_spawn_fail;
        if (w_restart) begin
            w_state      = S_IDLE;
            w_tries      = '0;
            w_scan       = 1'b0;
            w_scan_cnt   = '0;
            w_food_valid = 1'b0;
            w_spawn_fail = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: w_state = (i_game_state == 2'b00) ? S_PICK : S_IDLE;
                S_PICK: begin
                    if (r_tries >= T_MAX) begin
                        w_scan     = 1'b1;
                        w_scan_cnt = '0;
                        w_state    = S_QUERY;
                    end else if (w_in_range) begin
                        w_cx    = w_rx;
                        w_cy    = w_ry;
                        w_state = S_QUERY;
                    end else begin
                        w_tries = r_tries + 1'b1;
                    end
                end
                S_QUERY: w_state = S_WAIT;
                S_WAIT: begin
                    if (!i_occ_hit) begin
                        w_food_x     = r_cx;
                        w_food_y     = r_cy;
                        w_food_valid = 1'b1;
                        w_state      = S_ACTIVE;
                    end else if (r_scan) begin
                        if (r_scan_cnt == C_LAST) begin
                            w_spawn_fail = 1'b1;
                            w_food_valid = 1'b0;
                            w_state      = S_HALT;
                        end else begin
                            w_scan_cnt = r_scan_cnt + 1'b1;
                            w_cx       = w_sx;
                            w_cy       = w_sy;
                            w_state    = S_QUERY;
                        end
                    end else begin
                        w_tries = r_tries + 1'b1;
                        if (r_tries + 1'b1 >= T_MAX) begin
                            w_scan     = 1'b1;
                            w_scan_cnt = '0;
                            w_state    = S_QUERY;
                        end else begin
                            w_state = S_PICK;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_eat) begin
                        w_get_food   = 1'b1;
                        w_food_valid = 1'b0;
                        w_tries      = '0;
                        w_scan       = 1'b0;
                        w_state      = S_PICK;
                    end
                end
                S_HALT:  w_state = S_HALT;
                default: w_state = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset; the LFSR steps every cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_tries      <= '0;
            r_scan       <= 1'b0;
            r_scan_cnt   <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_food_x     <= '0;
            r_food_y     <= '0;
            r_food_valid <= 1'b0;
            r_get_food   <= 1'b0;
            r_spawn_fail <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_lfsr       <= w_lfsr;
            r_tries      <= w_tries;
            r_scan       <= w_scan;
            r_scan_cnt   <= w_scan_cnt;
            r_cx         <= w_cx;
            r_cy         <= w_cy;
            r_food_x     <= w_food_x;
            r_food_y     <= w_food_y;
            r_food_valid <= w_food_valid;
            r_get_food   <= w_get_food;
            r_spawn_fail <= w_spawn_fail;
        end
    end
endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: scoreboard bench for food placement, eating pulses, scan fallback and restart
module tb_food_spawner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] game_state = 2'b00;
    logic       move_tick = 1'b0;
    logic [4:0] head_x = '0;
    logic [4:0] head_y = '0;
    logic       occ_hit = 1'b0;
    logic       occ_req, food_valid, get_food, spawn_fail;
    logic [4:0] occ_x, occ_y, food_x, food_y;

    int         n_vec = 0;
    int         n_err = 0;
    int         nq = 0;
    int         n_gf = 0;
    int         mode = 0;
    int         hit_n = 0;
    logic       prev_fv = 1'b0;
    logic       prev_gf = 1'b0;
    logic [9:0] exp_q[$];
    int         g_q[$];

    food_spawner dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_game_state(game_state), .i_move_tick(move_tick),
        .i_head_x(head_x), .i_head_y(head_y), .o_occ_req(occ_req), .o_occ_x(occ_x),
        .o_occ_y(occ_y), .i_occ_hit(occ_hit), .o_food_x(food_x), .o_food_y(food_y),
        .o_food_valid(food_valid), .o_get_food(get_food), .o_spawn_fail(spawn_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Occupancy model: 0 all free, 1 first hit_n queries hit, 2 only (7,5) free, 3 all hit
    function automatic logic respond(input logic [4:0] x, input logic [4:0] y);
        case (mode)
            1:       return nq <= hit_n;
            2:       return !(x == 5'd7 && y == 5'd5);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (occ_req) begin
            nq++;
            occ_hit = respond(occ_x, occ_y);
            if (!occ_hit) exp_q.push_back({occ_y, occ_x});
        end
        if (food_valid && !prev_fv) begin
            if (exp_q.size() == 0) check("food_unexpected", exp_q.size(), 1);
            else check("food_cell", {food_y, food_x}, exp_q.pop_front());
            check("food_y_range", food_y < 5'd24, 1);
        end
        if (get_food) begin
            n_gf++;
            check("gf_expected", g_q.size() > 0, 1);
            if (g_q.size() > 0) void'(g_q.pop_front());
        end
        if (prev_gf) check("gf_width", get_food, 0);
        prev_fv = food_valid;
        prev_gf = get_food;
    endtask

    task automatic do_reset(input logic [1:0] gs);
        rst_n = 1'b0;
        game_state = gs;
        move_tick = 1'b0;
        occ_hit = 1'b0;
        step();
        step();
        check("rst_occ_req", occ_req, 0);
        check("rst_food_valid", food_valid, 0);
        check("rst_get_food", get_food, 0);
        check("rst_spawn_fail", spawn_fail, 0);
        check("rst_food_xy", {food_y, food_x}, 0);
        exp_q.delete();
        g_q.delete();
        nq = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_food(input int lim, input int min_lat);
        int k = 0;
        while (!food_valid && k < lim) begin
            step();
            k++;
        end
        check("food_valid", food_valid, 1);
        check("spawn_latency_min", k >= min_lat, 1);
    endtask

    task automatic eat(input logic on_food);
        logic exp;
        head_x = on_food ? food_x : food_x ^ 5'd1;
        head_y = food_y;
        exp = on_food && game_state == 2'b00 && food_valid;
        if (exp) g_q.push_back(1);
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        check("eat_pulse", get_food, exp);
        check("eat_food_valid", food_valid, !exp);
    endtask

    initial begin
        int k;
        int n;
        // T1: reset, paused IDLE holds, then a spawn that completes under pause
        do_reset(2'b11);
        game_state = 2'b01;
        repeat (5) step();
        check("idle_paused_no_query", nq, 0);
        mode = 0;
        game_state = 2'b00;
        step();
        game_state = 2'b01;
        wait_food(100, 2);
        check("t1_one_query", nq, 1);
        check("t1_no_get_food", n_gf, 0);
        // T2: miss then hit, one pulse, respawn at least 3 cycles later
        game_state = 2'b00;
        eat(1'b0);
        eat(1'b1);
        step();
        wait_food(300, 2);
        check("t2_pulses", n_gf, 1);
        // reset in the same cycle as an eat: no partial pulse
        rst_n = 1'b0;
        head_x = food_x;
        head_y = food_y;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        check("rst_eat_no_pulse", get_food, 0);
        check("rst_eat_fv", food_valid, 0);
        // T3: first three queries hit
        do_reset(2'b00);
        mode = 1;
        hit_n = 3;
        wait_food(300, 3);
        check("t3_queries", nq, 4);
        check("t3_queue_empty", exp_q.size(), 0);
        // T4: only (7,5) free, found by random or scan
        do_reset(2'b00);
        mode = 2;
        wait_food(4000, 3);
        check("t4_food", {food_y, food_x}, {5'd5, 5'd7});
        // T5: every cell occupied
        do_reset(2'b00);
        mode = 3;
        k = 0;
        while (!spawn_fail && k < 5000) begin
            step();
            k++;
        end
        check("t5_spawn_fail", spawn_fail, 1);
        check("t5_food_valid", food_valid, 0);
        check("t5_queries_min", nq >= 768, 1);
        check("t5_queries_max", nq <= 832, 1);
        n = nq;
        repeat (5) step();
        check("t5_halt_quiet", nq, n);
        check("t5_halt_sticky", spawn_fail, 1);
        game_state = 2'b10;
        step();
        check("t5_restart_clear", spawn_fail, 0);
        // T6: restart while waiting on the occupancy answer
        do_reset(2'b00);
        mode = 0;
        k = 0;
        while (!occ_req && k < 50) begin
            step();
            k++;
        end
        check("t6_query_seen", occ_req, 1);
        step();
        game_state = 2'b10;
        exp_q.delete();
        step();
        check("t6_occ_req", occ_req, 0);
        check("t6_food_valid", food_valid, 0);
        check("t6_get_food", get_food, 0);
        repeat (3) step();
        check("t6_stays_empty", food_valid, 0);
        n = nq;
        game_state = 2'b00;
        wait_food(300, 3);
        check("t6_one_query", nq, n + 1);
        game_state = 2'b01;
        eat(1'b1);
        repeat (3) step();
        check("t6_paused_no_pulse", n_gf, 1);
        game_state = 2'b00;
        eat(1'b1);
        step();
        check("t6_resumed_pulse", n_gf, 2);
        check("gf_queue_drained", g_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
